// File: rtl/keypad_number_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_number_entry_if
// Description : Keypad scan pins plus key and number outputs of
//               keypad_number_entry.
//               master = keypad / display side, slave = the entry block.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_number_entry_if;
   logic [3:0] row_in;        // rows, active-low, pulled up
   logic [3:0] col_out;       // column drive, active-low one-hot
   logic       key_valid;     // one-cycle pulse per debounced press
   logic [3:0] key_code;      // last debounced key code
   logic [6:0] entry;         // live entry value, 0-99
   logic [6:0] Number;        // committed value for the display
   logic       number_valid;  // one-cycle pulse when Number updates

   modport master (
      output row_in,
      input  col_out, key_valid, key_code, entry, Number, number_valid
   );

   modport slave (
      input  row_in,
      output col_out, key_valid, key_code, entry, Number, number_valid
   );
endinterface
`default_nettype wire

// File: rtl/keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_number_entry
// Description : 4x4 matrix keypad scanner with press/release debounce.
//               Decodes keys and builds a two-digit decimal entry (0-99).
//               '#' commits the entry to Number with a one-cycle strobe.
//               Optional macro AUTO_COMMIT_EN: every digit or '*' commits
//               the new entry immediately, and '#' commits nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_number_entry #(
   parameter int SCAN_DIV_BITS   = 17,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  wire logic              Clk,
   input  wire logic              Rst_n,
   keypad_number_entry_if.slave   kp
);

   localparam int                        c_deb_w      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_deb_w-1:0]        c_deb_last   = c_deb_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_deb_w-1:0]        c_deb_one    = c_deb_w'(1);
   localparam logic [SCAN_DIV_BITS-1:0]  c_dwell_last = '1;
   localparam logic [SCAN_DIV_BITS-1:0]  c_dwell_one  = SCAN_DIV_BITS'(1);
   localparam logic [3:0]                c_rows_idle  = 4'b1111;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t                   state_q,        state_d;
   logic [3:0]               row_meta_q,     row_meta_d;
   logic [3:0]               rs_q,           rs_d;
   logic [1:0]               col_idx_q,      col_idx_d;
   logic [3:0]               col_out_q,      col_out_d;
   logic [SCAN_DIV_BITS-1:0] dwell_q,        dwell_d;
   logic [c_deb_w-1:0]       deb_q,          deb_d;
   logic [3:0]               cap_rows_q,     cap_rows_d;
   logic [1:0]               cap_row_q,      cap_row_d;
   logic                     key_valid_q,    key_valid_d;
   logic [3:0]               key_code_q,     key_code_d;
   logic [6:0]               entry_q,        entry_d;
   logic [6:0]               number_q,       number_d;
   logic                     number_valid_q, number_valid_d;

   logic [3:0]               w_code;
   logic                     w_commit;

   // Lowest-index low row wins when several rows read low.
   function automatic logic [1:0] f_lowest_row(input logic [3:0] rows);
      if (!rows[0])      return 2'd0;
      else if (!rows[1]) return 2'd1;
      else if (!rows[2]) return 2'd2;
      else               return 2'd3;
   endfunction

   // Physical key position to key code ('*' = E, '#' = F).
   function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
      endcase
   endfunction

   // Commit to Number happens the cycle after key_valid so that Number and
   // number_valid change together and entry already holds its new value.
   always_comb begin
`ifdef AUTO_COMMIT_EN
      w_commit = key_valid_q && ((key_code_q <= 4'd9) || (key_code_q == 4'hE));
`else
      w_commit = key_valid_q && (key_code_q == 4'hF);
`endif
   end

   // Next-state logic: scan, debounce, held-key release wait, entry update.
   always_comb begin
      state_d        = state_q;
      row_meta_d     = kp.row_in;
      rs_d           = row_meta_q;
      col_idx_d      = col_idx_q;
      dwell_d        = dwell_q;
      deb_d          = deb_q;
      cap_rows_d     = cap_rows_q;
      cap_row_d      = cap_row_q;
      key_valid_d    = 1'b0;
      key_code_d     = key_code_q;
      entry_d        = entry_q;
      number_d       = number_q;
      number_valid_d = 1'b0;
      w_code         = f_key_code(cap_row_q, col_idx_q);

      if (w_commit) begin
         number_d       = entry_q;
         number_valid_d = 1'b1;
      end

      case (state_q)
         ST_SCAN: begin
            dwell_d = dwell_q + c_dwell_one;
            if (dwell_q == c_dwell_last) begin
               if (rs_q != c_rows_idle) begin
                  cap_rows_d = rs_q;
                  cap_row_d  = f_lowest_row(rs_q);
                  deb_d      = '0;
                  state_d    = ST_DEBOUNCE;
               end else begin
                  col_idx_d  = col_idx_q + 2'd1;
               end
            end
         end

         ST_DEBOUNCE: begin
            if (rs_q != cap_rows_q) begin
               // Bounce: abandon this column without emitting a key.
               state_d   = ST_SCAN;
               col_idx_d = col_idx_q + 2'd1;
               dwell_d   = '0;
            end else if (deb_q == c_deb_last) begin
               key_valid_d = 1'b1;
               key_code_d  = w_code;
               if (w_code <= 4'd9)
                  entry_d = ((entry_q % 7'd10) * 7'd10) + {3'b000, w_code};
               else if (w_code == 4'hE)
                  entry_d = '0;
               deb_d   = '0;
               state_d = ST_HELD;
            end else begin
               deb_d = deb_q + c_deb_one;
            end
         end

         ST_HELD: begin
            // Wait for a stable release; no auto-repeat.
            if (rs_q != c_rows_idle) begin
               deb_d = '0;
            end else if (deb_q == c_deb_last) begin
               deb_d     = '0;
               dwell_d   = '0;
               col_idx_d = col_idx_q + 2'd1;
               state_d   = ST_SCAN;
            end else begin
               deb_d = deb_q + c_deb_one;
            end
         end

         default: state_d = ST_SCAN;
      endcase

      col_out_d = ~(4'b0001 << col_idx_d);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q        <= ST_SCAN;
         row_meta_q     <= 4'b1111;
         rs_q           <= 4'b1111;
         col_idx_q      <= 2'd0;
         col_out_q      <= 4'b1110;
         dwell_q        <= '0;
         deb_q          <= '0;
         cap_rows_q     <= 4'b1111;
         cap_row_q      <= 2'd0;
         key_valid_q    <= 1'b0;
         key_code_q     <= 4'h0;
         entry_q        <= 7'd0;
         number_q       <= 7'd0;
         number_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_meta_q     <= row_meta_d;
         rs_q           <= rs_d;
         col_idx_q      <= col_idx_d;
         col_out_q      <= col_out_d;
         dwell_q        <= dwell_d;
         deb_q          <= deb_d;
         cap_rows_q     <= cap_rows_d;
         cap_row_q      <= cap_row_d;
         key_valid_q    <= key_valid_d;
         key_code_q     <= key_code_d;
         entry_q        <= entry_d;
         number_q       <= number_d;
         number_valid_q <= number_valid_d;
      end
   end

   assign kp.col_out      = col_out_q;
   assign kp.key_valid    = key_valid_q;
   assign kp.key_code     = key_code_q;
   assign kp.entry        = entry_q;
   assign kp.Number       = number_q;
   assign kp.number_valid = number_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_number_entry
// Description : Self-checking bench for keypad_number_entry with a keypad
//               model, directed scenarios and random key presses checked
//               against a digit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_number_entry;

   logic Clk = 1'b0;
   logic Rst_n;
   always #5 Clk = ~Clk;

   keypad_number_entry_if kif ();

   // Keypad model: a pressed key pulls its row low while its column is driven.
   logic       key_down;
   logic [1:0] key_row, key_col;
   assign kif.row_in = (key_down && (kif.col_out[key_col] == 1'b0)) ?
                       ~(4'b0001 << key_row) : 4'b1111;

   keypad_number_entry #(
      .SCAN_DIV_BITS   (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .kp    (kif.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Pulse monitor.
   int   kv_cnt = 0, nv_cnt = 0, double_pulse = 0;
   logic kv_prev = 1'b0, nv_prev = 1'b0;
   always @(negedge Clk) begin
      if (Rst_n === 1'b1) begin
         if (kif.key_valid)    kv_cnt++;
         if (kif.number_valid) nv_cnt++;
         if ((kif.key_valid && kv_prev) || (kif.number_valid && nv_prev)) double_pulse++;
      end
      kv_prev = kif.key_valid;
      nv_prev = kif.number_valid;
   end

   // Keypad layout as printed on the keys.
   logic [3:0] layout [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Reference model: the entry is the last two digits typed since the last clear.
   int         digits[$];
   logic [6:0] m_number = 7'd0;

   function automatic logic [6:0] m_entry();
      if (digits.size() == 0) return 7'd0;
      if (digits.size() == 1) return 7'(digits[0]);
      return 7'(10 * digits[digits.size()-2] + digits[digits.size()-1]);
   endfunction

   function automatic int model_press(input logic [3:0] code);
      int commit = 0;
      if (code <= 4'd9) begin
         digits.push_back(int'(code));
         if (digits.size() > 2) void'(digits.pop_front());
`ifdef AUTO_COMMIT_EN
         commit = 1;
`endif
      end else if (code == 4'hE) begin
         digits.delete();
`ifdef AUTO_COMMIT_EN
         commit = 1;
`endif
      end else if (code == 4'hF) begin
`ifndef AUTO_COMMIT_EN
         commit = 1;
`endif
      end
      if (commit != 0) m_number = m_entry();
      return commit;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_key(input logic [3:0] code);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (layout[r][c] == code) begin
               key_row = 2'(r);
               key_col = 2'(c);
            end
   endtask

   // Press a key until it is accepted, check the decode and commit, hold, release.
   task automatic press(input logic [3:0] code, input int hold);
      int kv0, nv0, exp_nv, got;
      kv0 = kv_cnt; nv0 = nv_cnt; exp_nv = 0; got = 0;
      set_key(code);
      key_down = 1'b1;
      for (int i = 0; i < 200 && got == 0; i++) begin
         @(negedge Clk);
         if (kif.key_valid === 1'b1) got = 1;
      end
      check("key_accepted", 32'(got), 32'd1);
      if (got != 0) begin
         exp_nv = model_press(code);
         check("key_code", 32'(kif.key_code), 32'(code));
         check("entry", 32'(kif.entry), 32'(m_entry()));
         @(negedge Clk);
         check("number_valid", 32'(kif.number_valid), 32'(exp_nv));
         check("Number", 32'(kif.Number), 32'(m_number));
      end
      repeat (hold) @(negedge Clk);
      key_down = 1'b0;
      repeat (25) @(negedge Clk);
      check("key_valid_count", 32'(kv_cnt - kv0), 32'd1);
      check("number_valid_count", 32'(nv_cnt - nv0), 32'(exp_nv));
      check("Number_held", 32'(kif.Number), 32'(m_number));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kv0, waited;
      logic [3:0] exp_col;
      key_down = 1'b0; key_row = 2'd0; key_col = 2'd0;
      Rst_n = 1'b0;

      // Reset state.
      repeat (3) @(negedge Clk);
      check("rst_col_out", 32'(kif.col_out), 32'h0E);
      check("rst_Number", 32'(kif.Number), 32'd0);
      check("rst_entry", 32'(kif.entry), 32'd0);
      check("rst_key_valid", 32'(kif.key_valid), 32'd0);
      check("rst_number_valid", 32'(kif.number_valid), 32'd0);
      check("rst_key_code", 32'(kif.key_code), 32'd0);
      Rst_n = 1'b1;

      // Idle column rotation, 4 clocks per column, wrapping after column 3.
      for (int i = 0; i < 20; i++) begin
         exp_col = ~(4'b0001 << ((i / 4) % 4));
         check("scan_col_out", 32'(kif.col_out), 32'(exp_col));
         @(negedge Clk);
      end

      // Entry 42 and commit.
      press(4'h4, 20);
      press(4'h2, 20);
      press(4'hF, 20);

      // Bounce on row2/col2 shorter than the debounce window.
      kv0 = kv_cnt; waited = 0;
      while (kif.col_out !== 4'b1011 && waited < 100) begin
         @(negedge Clk); waited++;
      end
      check("bounce_col_reached", 32'(kif.col_out), 32'h0B);
      set_key(4'h9);
      key_down = 1'b1;
      repeat (5) @(negedge Clk);
      key_down = 1'b0;
      repeat (25) @(negedge Clk);
      check("bounce_no_key", 32'(kv_cnt - kv0), 32'd0);
      check("bounce_entry", 32'(kif.entry), 32'(m_entry()));

      // Last two digits kept.
      press(4'h1, 10);
      press(4'h2, 10);
      press(4'h3, 10);
      press(4'hF, 10);

      // Letter, clear, commit.
      press(4'hA, 10);
      press(4'hE, 10);
      press(4'hF, 10);

      // Reset while a key is held.
      set_key(4'h5);
      key_down = 1'b1;
      waited = 0;
      while (kif.key_valid !== 1'b1 && waited < 200) begin
         @(negedge Clk); waited++;
      end
      check("hold5_accepted", 32'(kif.key_valid), 32'd1);
      check("hold5_code", 32'(kif.key_code), 32'h5);
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      check("midrst_col_out", 32'(kif.col_out), 32'h0E);
      check("midrst_entry", 32'(kif.entry), 32'd0);
      check("midrst_Number", 32'(kif.Number), 32'd0);
      check("midrst_key_valid", 32'(kif.key_valid), 32'd0);
      check("midrst_number_valid", 32'(kif.number_valid), 32'd0);
      key_down = 1'b0;
      Rst_n = 1'b1;
      digits.delete();
      m_number = 7'd0;
      kv0 = kv_cnt;
      repeat (20) @(negedge Clk);
      check("postrst_no_key", 32'(kv_cnt - kv0), 32'd0);
      check("postrst_entry", 32'(kif.entry), 32'd0);
      check("postrst_Number", 32'(kif.Number), 32'd0);

      // Digit then '#': behaviour depends on the commit mode.
      press(4'h7, 10);
      press(4'hF, 10);

      // Random key presses against the reference model.
      for (int n = 0; n < 12; n++)
         press(4'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

      check("no_back_to_back_pulses", 32'(double_pulse), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
